axil_dmem: RTL
==============

Name: axil_dmem

Overview:
- Parametrised AXI4-Lite data-memory slave; successor to the fixed 32-bit, word-addressed core data memory.
- Generalised data width, byte addressing with a base-address window, independent AW/W acceptance, and responses held until accepted.
- Returns SLVERR on out-of-window accesses.
- Sits on the core's data bus (LSU master) and backs all load/store traffic.

Parameters:
AXI_AWIDTH, 32, byte-address width
AXI_DWIDTH, 32, data width; 32 or 64
DEPTH, 1024, number of AXI_DWIDTH-bit words
BASE_ADDR, 32'h0, byte address of word 0; must be aligned to AXI_DWIDTH/8

Ports:
AXI_ACLK  in  1  clock
AXI_ARESETN  in  1  asynchronous active-low reset
AXI_AWADDR  in  AXI_AWIDTH  write byte address
AXI_AWVALID  in  1  write address valid
AXI_AWREADY  out  1  write address ready
AXI_WDATA  in  AXI_DWIDTH  write data
AXI_WSTRB  in  AXI_DWIDTH/8  byte enables
AXI_WVALID  in  1  write data valid
AXI_WREADY  out  1  write data ready
AXI_BRESP  out  2  write response
AXI_BVALID  out  1  write response valid
AXI_BREADY  in  1  write response ready
AXI_ARADDR  in  AXI_AWIDTH  read byte address
AXI_ARVALID  in  1  read address valid
AXI_ARREADY  out  1  read address ready
AXI_RDATA  out  AXI_DWIDTH  read data
AXI_RRESP  out  2  read response
AXI_RVALID  out  1  read data valid
AXI_RREADY  in  1  read data ready

Behaviour:
Reset and addressing:
- Reset is asynchronous assert, synchronous release. While AXI_ARESETN is low: AWREADY=WREADY=ARREADY=BVALID=RVALID=0, BRESP=RRESP=0, RDATA=0.
- The rst_done flop sets on the first clock edge after release. All READY outputs are gated with rst_done.
- Memory contents are not reset.
- Word index = (addr - BASE_ADDR) >> log2(AXI_DWIDTH/8). Low address bits are ignored; no misalignment error.
- In range iff BASE_ADDR <= addr < BASE_ADDR + DEPTH*AXI_DWIDTH/8.

Write FSM (W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP):
- AWREADY = state in {W_IDLE, W_HAVE_W}; WREADY = state in {W_IDLE, W_HAVE_AW}.
- W_IDLE:
  - AW and W handshake in the same cycle -> write performed at that edge, go to W_RESP.
  - AW only -> latch address, go to W_HAVE_AW.
  - W only -> latch data and strobe, go to W_HAVE_W.
- W_HAVE_AW + W handshake, or W_HAVE_W + AW handshake -> write at that edge, go to W_RESP.
- The write updates only the bytes whose WSTRB bit is 1. WSTRB = 0 is a legal no-op and returns OKAY.
- Out-of-range write: memory untouched, BRESP=2'b10 (SLVERR). Otherwise BRESP=2'b00.
- W_RESP: BVALID=1 with BRESP stable until the BVALID&BREADY edge, then W_IDLE. No new AW/W is accepted in W_RESP.

Read FSM (R_IDLE, R_VALID):
- ARREADY = (state == R_IDLE).
- AR handshake at edge N: RDATA=mem[idx] (or 0 with RRESP=SLVERR if out of range), RVALID=1 after edge N; go to R_VALID.
- RDATA, RRESP and RVALID are held stable until the RVALID&RREADY edge, then R_IDLE. Throughput is one read per 2 cycles.

Boundary conditions:
- A write and a read to the same word at the same edge: the read returns pre-write data.
- Reset mid-transaction drops latched AW/W and pending B/R responses. The master must reissue.
- BREADY or RREADY asserted early (before VALID) has no effect.

Decomposition:
- axil_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the write/read state encodings.
- Sub-module dmem_ram: DEPTH x AXI_DWIDTH synchronous RAM with one byte-enabled write port and one registered read port.

Test Plan:
- Reset released, AW=0x8/W=0xAABBCCDD/WSTRB=4'hF same cycle, BREADY=1 -> BVALID one cycle after handshake, BRESP=0. Read 0x8 -> RDATA=0xAABBCCDD, RRESP=0.
- AW=0x10 issued 3 cycles before W=0x11223344 -> AWREADY drops after the AW handshake, WREADY stays 1. Single write, BRESP=0. Repeat with W before AW -> same result.
- Word 0x4 preset to 0xFFFFFFFF, write 0x00000000 with WSTRB=4'b0101 -> readback 0xFF00FF00.
- BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout. Same check for RVALID/RDATA with RREADY=0.
- DEPTH=1024, write 0x1000 -> BRESP=2'b10, memory unchanged. Read 0x1000 -> RDATA=0, RRESP=2'b10. Read 0xFFC -> RRESP=0.
- AWVALID/WVALID held, ARESETN pulsed low while in W_HAVE_AW -> all VALID/READY 0 immediately. After release, no B response is issued for the dropped write.

Source files
------------

// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared definitions for the AXI4-Lite data memory: response
//                codes and the write/read channel state encodings.
//  Contents    : RESP_OKAY, RESP_SLVERR, wr_state_t, rd_state_t
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Write channel: AW and W may arrive in either order or together.
   typedef enum logic [1:0] {
      W_IDLE    = 2'd0,
      W_HAVE_AW = 2'd1,
      W_HAVE_W  = 2'd2,
      W_RESP    = 2'd3
   } wr_state_t;

   // Read channel: one outstanding read, response held until accepted.
   typedef enum logic {
      R_IDLE  = 1'b0,
      R_VALID = 1'b1
   } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : DEPTH x DWIDTH synchronous RAM, one byte-enabled write port
//                and one registered read port. Contents are not reset. A read
//                and a write to the same word at one edge return old data.
//  Ports       : i_clk    - clock
//                i_we     - write enable (gated per byte by i_wstrb)
//                i_waddr  - write word index
//                i_wdata  - write data
//                i_wstrb  - byte enables
//                i_re     - read enable (o_rdata updates only when set)
//                i_raddr  - read word index
//                o_rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 1024,
   parameter int IDX_W  = 10
) (
   input  logic                i_clk,
   input  logic                i_we,
   input  logic [IDX_W-1:0]    i_waddr,
   input  logic [DWIDTH-1:0]   i_wdata,
   input  logic [DWIDTH/8-1:0] i_wstrb,
   input  logic                i_re,
   input  logic [IDX_W-1:0]    i_raddr,
   output logic [DWIDTH-1:0]   o_rdata
);

   localparam int c_NBYTES = DWIDTH / 8;

   logic [DWIDTH-1:0] r_mem [0:DEPTH-1];
   logic [DWIDTH-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int b = 0; b < c_NBYTES; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/axil_dmem.sv
`default_nettype none
// ============================================================================
//  Module      : axil_dmem
//  Description : AXI4-Lite data-memory slave. Byte-addressed window starting
//                at BASE_ADDR, DEPTH words of AXI_DWIDTH bits. AW and W are
//                accepted independently; B and R responses are held until
//                accepted. Accesses outside the window return SLVERR and do
//                not touch memory.
//  Ports       : AXI_ACLK / AXI_ARESETN       - clock, async active-low reset
//                AXI_AW* / AXI_W* / AXI_B*    - write address, data, response
//                AXI_AR* / AXI_R*             - read address, data/response
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_dmem
   import axil_pkg::*;
#(
   parameter int                    AXI_AWIDTH = 32,
   parameter int                    AXI_DWIDTH = 32,
   parameter int                    DEPTH      = 1024,
   parameter logic [AXI_AWIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                    AXI_ACLK,
   input  logic                    AXI_ARESETN,
   input  logic [AXI_AWIDTH-1:0]   AXI_AWADDR,
   input  logic                    AXI_AWVALID,
   output logic                    AXI_AWREADY,
   input  logic [AXI_DWIDTH-1:0]   AXI_WDATA,
   input  logic [AXI_DWIDTH/8-1:0] AXI_WSTRB,
   input  logic                    AXI_WVALID,
   output logic                    AXI_WREADY,
   output logic [1:0]              AXI_BRESP,
   output logic                    AXI_BVALID,
   input  logic                    AXI_BREADY,
   input  logic [AXI_AWIDTH-1:0]   AXI_ARADDR,
   input  logic                    AXI_ARVALID,
   output logic                    AXI_ARREADY,
   output logic [AXI_DWIDTH-1:0]   AXI_RDATA,
   output logic [1:0]              AXI_RRESP,
   output logic                    AXI_RVALID,
   input  logic                    AXI_RREADY
);

   localparam int c_BYTES    = AXI_DWIDTH / 8;
   localparam int c_ADDR_LSB = $clog2(c_BYTES);
   localparam int c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Window size in bytes, one bit wider than the address so that a window
   // reaching the top of the address space is still representable.
   localparam logic [AXI_AWIDTH:0] c_MEM_BYTES = (AXI_AWIDTH+1)'(DEPTH * c_BYTES);

   // ------------------------------------------------------------------------
   // Reset release tracking: READY outputs stay low until the first edge
   // after AXI_ARESETN rises.
   // ------------------------------------------------------------------------
   logic r_rst_done;

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         r_rst_done <= 1'b0;
      end else begin
         r_rst_done <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------------
   wr_state_t               r_wstate;
   logic [AXI_AWIDTH-1:0]   r_awaddr;
   logic [AXI_DWIDTH-1:0]   r_wdata;
   logic [c_BYTES-1:0]      r_wstrb;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;

   logic                    w_awready;
   logic                    w_wready;
   logic                    w_aw_fire;
   logic                    w_w_fire;
   logic                    w_wr_go;
   logic [AXI_AWIDTH-1:0]   w_wr_addr;
   logic [AXI_DWIDTH-1:0]   w_wr_data;
   logic [c_BYTES-1:0]      w_wr_strb;
   logic [AXI_AWIDTH:0]     w_wr_diff;
   logic                    w_wr_inr;
   logic [c_IDX_W-1:0]      w_wr_idx;

   assign w_awready = r_rst_done && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_W));
   assign w_wready  = r_rst_done && ((r_wstate == W_IDLE) || (r_wstate == W_HAVE_AW));
   assign w_aw_fire = AXI_AWVALID && w_awready;
   assign w_w_fire  = AXI_WVALID  && w_wready;

   // The write happens on the edge that completes the AW/W pair, whichever
   // half arrived last.
   assign w_wr_go = ((r_wstate == W_IDLE)    && w_aw_fire && w_w_fire) ||
                    ((r_wstate == W_HAVE_AW) && w_w_fire) ||
                    ((r_wstate == W_HAVE_W)  && w_aw_fire);

   // Take whichever half was latched earlier, otherwise the live bus value.
   assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : AXI_AWADDR;
   assign w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata  : AXI_WDATA;
   assign w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : AXI_WSTRB;

   // The extra MSB catches addresses below BASE_ADDR: the borrow makes the
   // difference exceed the window size, so one compare covers both bounds.
   assign w_wr_diff = {1'b0, w_wr_addr} - {1'b0, BASE_ADDR};
   assign w_wr_inr  = (w_wr_diff < c_MEM_BYTES);
   assign w_wr_idx  = c_IDX_W'(w_wr_diff >> c_ADDR_LSB);

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         r_wstate <= W_IDLE;
         r_awaddr <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_bvalid <= 1'b0;
         r_bresp  <= RESP_OKAY;
      end else begin
         case (r_wstate)
            W_IDLE: begin
               if (w_aw_fire && w_w_fire) begin
                  r_wstate <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_inr ? RESP_OKAY : RESP_SLVERR;
               end else if (w_aw_fire) begin
                  r_awaddr <= AXI_AWADDR;
                  r_wstate <= W_HAVE_AW;
               end else if (w_w_fire) begin
                  r_wdata  <= AXI_WDATA;
                  r_wstrb  <= AXI_WSTRB;
                  r_wstate <= W_HAVE_W;
               end
            end
            W_HAVE_AW: begin
               if (w_w_fire) begin
                  r_wstate <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_inr ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_HAVE_W: begin
               if (w_aw_fire) begin
                  r_wstate <= W_RESP;
                  r_bvalid <= 1'b1;
                  r_bresp  <= w_wr_inr ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (AXI_BREADY) begin
                  r_wstate <= W_IDLE;
                  r_bvalid <= 1'b0;
               end
            end
            default: begin
               r_wstate <= W_IDLE;
               r_bvalid <= 1'b0;
            end
         endcase
      end
   end

   assign AXI_AWREADY = w_awready;
   assign AXI_WREADY  = w_wready;
   assign AXI_BVALID  = r_bvalid;
   assign AXI_BRESP   = r_bresp;

   // ------------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------------
   rd_state_t               r_rstate;
   logic                    r_rvalid;
   logic [1:0]              r_rresp;

   logic                    w_arready;
   logic                    w_ar_fire;
   logic [AXI_AWIDTH:0]     w_rd_diff;
   logic                    w_rd_inr;
   logic [c_IDX_W-1:0]      w_rd_idx;
   logic [AXI_DWIDTH-1:0]   w_ram_rdata;

   assign w_arready = r_rst_done && (r_rstate == R_IDLE);
   assign w_ar_fire = AXI_ARVALID && w_arready;

   assign w_rd_diff = {1'b0, AXI_ARADDR} - {1'b0, BASE_ADDR};
   assign w_rd_inr  = (w_rd_diff < c_MEM_BYTES);
   assign w_rd_idx  = c_IDX_W'(w_rd_diff >> c_ADDR_LSB);

   always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
      if (!AXI_ARESETN) begin
         r_rstate <= R_IDLE;
         r_rvalid <= 1'b0;
         r_rresp  <= RESP_OKAY;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (w_ar_fire) begin
                  r_rstate <= R_VALID;
                  r_rvalid <= 1'b1;
                  r_rresp  <= w_rd_inr ? RESP_OKAY : RESP_SLVERR;
               end
            end
            R_VALID: begin
               if (AXI_RREADY) begin
                  r_rstate <= R_IDLE;
                  r_rvalid <= 1'b0;
               end
            end
            default: begin
               r_rstate <= R_IDLE;
               r_rvalid <= 1'b0;
            end
         endcase
      end
   end

   // The RAM read register only loads on an in-range AR handshake, so it
   // holds its value for the whole R_VALID phase. Masking keeps RDATA at zero
   // during reset, between responses and for SLVERR reads.
   assign AXI_ARREADY = w_arready;
   assign AXI_RVALID  = r_rvalid;
   assign AXI_RRESP   = r_rresp;
   assign AXI_RDATA   = (r_rvalid && (r_rresp == RESP_OKAY)) ? w_ram_rdata : '0;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   dmem_ram #(
      .DWIDTH (AXI_DWIDTH),
      .DEPTH  (DEPTH),
      .IDX_W  (c_IDX_W)
   ) u_ram (
      .i_clk   (AXI_ACLK),
      .i_we    (w_wr_go && w_wr_inr),
      .i_waddr (w_wr_idx),
      .i_wdata (w_wr_data),
      .i_wstrb (w_wr_strb),
      .i_re    (w_ar_fire && w_rd_inr),
      .i_raddr (w_rd_idx),
      .o_rdata (w_ram_rdata)
   );

endmodule
`default_nettype wire
